// File: rtl/isqrt_seq.sv
// ---------------------------------------------------------------------------
// isqrt_seq -- sequential 32-bit integer square root with a request FIFO.
//
// Requests are queued in a small FIFO and processed one at a time by a
// radix-4 digit-recurrence core that retires one root bit per clock.
// Results come out strictly in request order, one y_vld pulse each.
//
// Ports
//   clk       in   1   clock, all state changes on the rising edge
//   rst       in   1   synchronous, active-high reset
//   x_vld     in   1   request strobe (no backpressure)
//   x         in  32   unsigned radicand
//   y_vld     out  1   one-cycle result strobe
//   y         out 16   floor(sqrt(x)) of the oldest accepted request
//   busy      out  1   FIFO non-empty or core computing
//   overflow  out  1   sticky: a request was dropped on a full FIFO
//
// Timing: an idle block accepting a request in cycle N raises y_vld in
// cycle N+18 (write edge, pop edge, 16 iterations). Back-to-back results
// are 17 cycles apart because the pop happens in the IDLE cycle that
// coincides with the previous y_vld.
// ---------------------------------------------------------------------------
module isqrt_seq #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("isqrt_seq: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // One radix-4 digit step. The remainder is 18 bits so that the shifted
    // remainder (at most 4*65534+3) and the trial value (at most 4*32767+1)
    // never lose bits; the returned value is {new_rem, new_root}.
    // -----------------------------------------------------------------------
    function automatic logic [33:0] f_digit_step(
        input logic [17:0] rem,
        input logic [15:0] root,
        input logic [1:0]  pair
    );
        logic [17:0] rem_sh;
        logic [17:0] trial;
        logic [15:0] root_sh;
        rem_sh  = (rem << 2) | {16'd0, pair};
        trial   = {root, 2'b01};
        root_sh = root << 1;
        if (rem_sh >= trial) begin
            return {rem_sh - trial, root_sh | 16'd1};
        end
        return {rem_sh, root_sh};
    endfunction

    // Request FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [31:0]  r_mem [FIFO_DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;

    // Core state
    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_cnt;
    logic [31:0]  r_rad;
    logic [17:0]  r_rem;
    logic [15:0]  r_root;

    // Output registers
    logic         r_y_vld;
    logic [15:0]  r_y;
    logic         r_ovf;

    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_push;
    logic         w_last;
    logic [33:0]  w_step;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // The core only takes a new radicand while idle; a push to a full FIFO
    // still succeeds when the head leaves on the same edge.
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_push  = x_vld && (!w_full || w_pop);
    assign w_last  = (r_state == S_CALC) && (r_cnt == 4'd0);

    // The radicand register is shifted left two bits per iteration, so its
    // top pair is always x[2i+1:2i] for the current counter value i.
    assign w_step  = f_digit_step(r_rem, r_root, r_rad[31:30]);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO storage (data only, pointers decide what is valid)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= x;
        end
    end

    // -----------------------------------------------------------------------
    // Control: pointers, iteration counter, result strobe, overflow
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= 4'd0;
            r_y_vld <= 1'b0;
            r_y     <= 16'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (x_vld && !w_push) begin
                r_ovf <= 1'b1;
            end

            if (w_pop) begin
                r_cnt <= 4'd15;
            end else if ((r_state == S_CALC) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            r_y_vld <= w_last;
            if (w_last) begin
                r_y <= w_step[15:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: radicand, remainder, partial root
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_rad  <= r_mem[r_rptr[AW-1:0]];
            r_rem  <= 18'd0;
            r_root <= 16'd0;
        end else if (r_state == S_CALC) begin
            r_rad  <= r_rad << 2;
            r_rem  <= w_step[33:16];
            r_root <= w_step[15:0];
        end
    end

    assign y_vld    = r_y_vld;
    assign y        = r_y;
    assign overflow = r_ovf;
    assign busy     = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_isqrt_seq.sv
// ---------------------------------------------------------------------------
// tb_isqrt_seq -- directed and randomized self-checking bench for isqrt_seq.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point (settled values of the current cycle). A negedge monitor
// compares every result against an in-order queue of expected roots.
// ---------------------------------------------------------------------------
module tb_isqrt_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;
    logic        busy;
    logic        overflow;

    int          n_vec  = 0;
    int          n_err  = 0;
    int          cyc    = 0;
    int          n_recv = 0;
    logic [15:0] exp_q[$];
    int          vq[$];

    isqrt_seq #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .x_vld    (x_vld),
        .x        (x),
        .y_vld    (y_vld),
        .y        (y),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Bit-by-bit search using squares; independent of the digit recurrence.
    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] c;
        logic [63:0] cc;
        r = 16'd0;
        for (int b = 15; b >= 0; b--) begin
            c  = r | (16'd1 << b);
            cc = 64'(c);
            if (cc * cc <= 64'(v)) r = c;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (y_vld) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_y_vld", 32'd1, 32'd0);
            end else begin
                chk("y_value", 32'(y), 32'(exp_q.pop_front()));
            end
            n_recv++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance until cycle n0+last, logging y_vld offsets relative to n0.
    task automatic run_until(input int n0, input int last);
        while (cyc < n0 + last) begin
            tick();
            if (y_vld) vq.push_back(cyc - n0);
        end
    endtask

    task automatic do_single(input logic [31:0] xv, input logic [15:0] yv);
        int n0;
        vq.delete();
        n0    = cyc;
        x_vld = 1'b1;
        x     = xv;
        exp_q.push_back(yv);
        tick();
        x_vld = 1'b0;
        chk("single_busy", 32'(busy), 32'd1);
        run_until(n0, 20);
        chk("single_count", 32'(vq.size()), 32'd1);
        chk("single_latency", (vq.size() > 0) ? 32'(vq[0]) : 32'hFFFF_FFFF, 32'd18);
        chk("single_y_hold", 32'(y), 32'(yv));
        chk("single_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    logic [31:0] sx [6];
    logic [15:0] sy [6];
    logic [31:0] bx [4];
    logic [15:0] by [4];
    logic [31:0] qx [6];
    logic [15:0] qy [6];
    int          offs4 [4];
    int          offs5 [5];

    initial begin
        int n0;
        int sent;
        int budget;
        logic [31:0] rv;

        sx = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF, 32'hFFFE_0001};
        sy = '{16'd0, 16'd1, 16'd3,  16'd4,  16'hFFFF,      16'hFFFF};
        bx = '{32'd100, 32'd144, 32'd2, 32'd3};
        by = '{16'd10,  16'd12,  16'd1, 16'd1};
        offs4 = '{18, 35, 52, 69};
        qx = '{32'd25, 32'd36, 32'd49, 32'd64, 32'd81, 32'd121};
        qy = '{16'd5,  16'd6,  16'd7,  16'd8,  16'd9,  16'd11};
        offs5 = '{18, 35, 52, 69, 86};

        // Reset with x_vld held high: requests must be ignored.
        rst   = 1'b1;
        x_vld = 1'b1;
        x     = 32'd16;
        repeat (3) tick();
        chk("rst_y_vld", 32'(y_vld), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst   = 1'b0;
        x_vld = 1'b0;
        vq.delete();
        n0 = cyc;
        run_until(n0, 25);
        chk("rst_ignored_req", 32'(vq.size()), 32'd0);

        // Single requests on an idle block.
        for (int i = 0; i < 6; i++) begin
            do_single(sx[i], sy[i]);
        end

        // Back-to-back requests, 17-cycle result spacing.
        vq.delete();
        n0 = cyc;
        for (int i = 0; i < 4; i++) begin
            x_vld = 1'b1;
            x     = bx[i];
            exp_q.push_back(by[i]);
            tick();
        end
        x_vld = 1'b0;
        run_until(n0, 75);
        chk("b2b_count", 32'(vq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_offset", (i < vq.size()) ? 32'(vq[i]) : 32'hFFFF_FFFF, 32'(offs4[i]));
        end
        chk("b2b_overflow", 32'(overflow), 32'd0);

        // Six requests into a 4-deep FIFO: the sixth is dropped.
        vq.delete();
        n0 = cyc;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("ovf_before_drop", 32'(overflow), 32'd0);
            x_vld = 1'b1;
            x     = qx[i];
            if (i < 5) exp_q.push_back(qy[i]);
            tick();
        end
        x_vld = 1'b0;
        chk("ovf_after_drop", 32'(overflow), 32'd1);
        run_until(n0, 85);
        chk("ovf_busy_before_last", 32'(busy), 32'd1);
        run_until(n0, 87);
        chk("ovf_busy_after_last", 32'(busy), 32'd0);
        run_until(n0, 110);
        chk("ovf_count", 32'(vq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("ovf_offset", (i < vq.size()) ? 32'(vq[i]) : 32'hFFFF_FFFF, 32'(offs5[i]));
        end
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-computation with two requests queued.
        vq.delete();
        n0 = cyc;
        for (int i = 0; i < 3; i++) begin
            x_vld = 1'b1;
            x     = 32'd1000 * (i + 1);
            tick();
        end
        x_vld = 1'b0;
        while (cyc < n0 + 10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        chk("midrst_y", 32'(y), 32'd0);
        chk("midrst_y_vld", 32'(y_vld), 32'd0);
        run_until(n0, 90);
        chk("midrst_no_results", 32'(vq.size()), 32'd0);

        // First request after reset keeps the normal latency.
        do_single(32'd1_000_000, 16'd1000);

        // New request in the exact y_vld cycle of the previous result.
        vq.delete();
        n0    = cyc;
        x_vld = 1'b1;
        x     = 32'd400;
        exp_q.push_back(16'd20);
        tick();
        x_vld = 1'b0;
        while (cyc < n0 + 18) tick();
        chk("ovl_first_vld", 32'(y_vld), 32'd1);
        vq.push_back(cyc - n0);
        x_vld = 1'b1;
        x     = 32'd9;
        exp_q.push_back(16'd3);
        tick();
        x_vld = 1'b0;
        run_until(n0, 40);
        chk("ovl_count", 32'(vq.size()), 32'd2);
        chk("ovl_second_offset", (vq.size() > 1) ? 32'(vq[1]) : 32'hFFFF_FFFF, 32'd36);

        // Random soak, paced to never overrun the FIFO.
        n_recv = 0;
        sent   = 0;
        budget = 0;
        while ((sent < 1000) && (budget < 40000)) begin
            if (((sent - n_recv) < 4) && ($urandom_range(0, 3) == 0)) begin
                case ($urandom_range(0, 7))
                    0:       rv = $urandom_range(0, 300);
                    1:       rv = 32'hFFFF_FFFF - $urandom_range(0, 300);
                    default: rv = $urandom;
                endcase
                x_vld = 1'b1;
                x     = rv;
                exp_q.push_back(ref_sqrt(rv));
                sent++;
            end else begin
                x_vld = 1'b0;
            end
            tick();
            budget++;
        end
        x_vld = 1'b0;
        budget = 0;
        while ((n_recv < sent) && (budget < 200)) begin
            tick();
            budget++;
        end
        chk("soak_sent", 32'(sent), 32'd1000);
        chk("soak_received", 32'(n_recv), 32'(sent));
        chk("soak_overflow", 32'(overflow), 32'd0);
        chk("soak_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
